// File: rtl/shift_right_iterative_pkg.sv
// Shared ALU shifter definitions: FSM encoding, default width and shift-mode constants.
package shift_right_iterative_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } shift_state_t;

   localparam int SHIFT_N = 32;

   localparam logic SHIFT_LOGICAL = 1'b0;
   localparam logic SHIFT_ARITH   = 1'b1;

endpackage

// File: rtl/shift_right_stage.sv
// One log-stage of the right shifter: shifts by 2^k with fill when enabled, else passes data.
module shift_right_stage
   import shift_right_iterative_pkg::*;
#(
   parameter int N = SHIFT_N,
   parameter int L = $clog2(N)
) (
   input  logic [N-1:0] data,
   input  logic [L-1:0] k,
   input  logic         en,
   input  logic         fill,
   output logic [N-1:0] result
);

   logic [N-1:0] cand [L];

   for (genvar j = 0; j < L; j++) begin : g_stage
      localparam int SH = 1 << j;
      assign cand[j] = {{SH{fill}}, data[N-1:SH]};
   end

   always_comb begin
      result = data;
      for (int j = 0; j < L; j++) begin
         if (en && (k == L'(j))) result = cand[j];
      end
   end

endmodule

// File: rtl/shift_right_iterative.sv
// Multi-cycle SRL/SRA unit: one shamt bit resolved per clock behind a valid/ready handshake.
//
// state   | meaning
// S_IDLE  | ready for an operand; capture data, amount and fill on in_valid
// S_SHIFT | apply stage k (shift by 2^k if amt[k]); exactly L cycles
// S_DONE  | result presented on out until out_ready
module shift_right_iterative
   import shift_right_iterative_pkg::*;
#(
   parameter int N = SHIFT_N,
   localparam int L = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in,
   input  logic [L-1:0] shamt,
   input  logic         arith,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out,
   output logic         busy
);

   localparam logic [L-1:0] K_LAST = L'(L - 1);

   shift_state_t state, state_nxt;
   logic [N-1:0] data_q;
   logic [N-1:0] stage_out;
   logic [L-1:0] amt_q;
   logic [L-1:0] k_q;
   logic         fill_q;

   shift_right_stage #(.N(N), .L(L)) u_stage (
      .data   (data_q),
      .k      (k_q),
      .en     (amt_q[k_q]),
      .fill   (fill_q),
      .result (stage_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         data_q <= '0;
         amt_q  <= '0;
         k_q    <= '0;
         fill_q <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  data_q <= in;
                  amt_q  <= shamt;
                  fill_q <= (arith == SHIFT_ARITH) & in[N-1];
                  k_q    <= '0;
               end
            end
            S_SHIFT: begin
               data_q <= stage_out;
               k_q    <= k_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            if (k_q == K_LAST) state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign out = data_q;

endmodule

// File: tb/tb_shift_right_iterative.sv
// Self-checking bench for shift_right_iterative: directed cases, backpressure, reset abort, random sweep.
module tb_shift_right_iterative;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] din;
   logic [4:0]  shamt;
   logic        arith;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] dout;
   logic        busy;

   int checks = 0;
   int errors = 0;

   shift_right_iterative #(.N(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (din),
      .shamt     (shamt),
      .arith     (arith),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (dout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [31:0] d, input int s, input logic a);
      if (a) return 32'($signed(d) >>> s);
      return d >> s;
   endfunction

   // Present an operand, wait for acceptance, then scramble inputs to prove they are sampled once.
   task automatic start_op(input logic [31:0] d, input logic [4:0] s, input logic a);
      int guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
      end
      din = d; shamt = s; arith = a; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      din = $urandom; shamt = 5'($urandom); arith = 1'($urandom);
   endtask

   // Called #1 after the accept edge; lat counts edges from acceptance inclusive.
   task automatic wait_result(output logic [31:0] r, output int lat, output logic rdy_low);
      lat = 1;
      rdy_low = 1'b1;
      while (!out_valid && lat < 20) begin
         if (in_ready) rdy_low = 1'b0;
         @(posedge clk); #1; lat++;
      end
      checks++;
      if (!out_valid) begin
         errors++;
         $display("FAIL result_timeout: out_valid=%0b required 1", out_valid);
      end
      r = dout;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; din = '0; shamt = '0; arith = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, busy, dout} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL reset_state: rdy/ov/busy/out=%b/%b/%b/%h required 1/0/0/00000000",
                  in_ready, out_valid, busy, dout);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed;
      logic [31:0] tv_d [6] = '{32'hF000_0000, 32'hF000_0000, 32'h8000_0001, 32'h8000_0001,
                               32'hDEAD_BEEF, 32'hDEAD_BEEF};
      logic [4:0]  tv_s [6] = '{5'd4, 5'd4, 5'd31, 5'd31, 5'd0, 5'd0};
      logic        tv_a [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [31:0] tv_e [6] = '{32'h0F00_0000, 32'hFF00_0000, 32'hFFFF_FFFF, 32'h0000_0001,
                               32'hDEAD_BEEF, 32'hDEAD_BEEF};
      logic [31:0] r;
      int          lat;
      logic        rl;
      for (int i = 0; i < 6; i++) begin
         start_op(tv_d[i], tv_s[i], tv_a[i]);
         wait_result(r, lat, rl);
         checks++;
         if (r !== tv_e[i]) begin
            errors++;
            $display("FAIL directed_out[%0d]: out=%h required %h", i, r, tv_e[i]);
         end
         checks++;
         if (lat != 6) begin
            errors++;
            $display("FAIL directed_latency[%0d]: edges=%0d required 6", i, lat);
         end
         checks++;
         if (!rl) begin
            errors++;
            $display("FAIL directed_in_ready[%0d]: in_ready high during shift, required low", i);
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL directed_release[%0d]: out_valid=%b in_ready=%b required 0/1",
                     i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] r, r2;
      int          lat;
      logic        rl;
      start_op(32'hF000_0000, 5'd4, 1'b0);
      wait_result(r, lat, rl);
      din = 32'h1234_5678; shamt = 5'd8; arith = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || dout !== 32'h0F00_0000 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: ov=%b out=%h rdy=%b required 1/0f000000/0",
                     i, out_valid, dout, in_ready);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_release: ov=%b rdy=%b required 0/1", out_valid, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      din = $urandom;
      wait_result(r2, lat, rl);
      checks++;
      if (r2 !== 32'h0012_3456 || lat != 6) begin
         errors++;
         $display("FAIL stall_next_op: out=%h lat=%0d required 00123456/6", r2, lat);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_midshift;
      logic [31:0] r;
      int          lat;
      logic        rl;
      start_op(32'hFFFF_FFFF, 5'd3, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, busy, dout} !== {1'b0, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL reset_abort: ov/busy/out=%b/%b/%h required 0/0/00000000",
                  out_valid, busy, dout);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_recover: rdy=%b ov=%b required 1/0", in_ready, out_valid);
      end
      start_op(32'h0000_0100, 5'd8, 1'b0);
      wait_result(r, lat, rl);
      checks++;
      if (r !== 32'h0000_0001) begin
         errors++;
         $display("FAIL reset_next_op: out=%h required 00000001", r);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_random;
      logic [31:0] d, r, exp_q[$];
      logic [4:0]  s;
      logic        a, rl, hold;
      int          lat, stall, got;
      got = 0;
      for (int n = 0; n < 1000; n++) begin
         d = $urandom; s = 5'($urandom_range(0, 31)); a = 1'($urandom_range(0, 1));
         hold = 1'($urandom_range(0, 1));
         exp_q.push_back(model(d, int'(s), a));
         out_ready = hold;
         start_op(d, s, a);
         wait_result(r, lat, rl);
         got++;
         checks++;
         if (r !== exp_q[0] || lat != 6 || !rl) begin
            errors++;
            $display("FAIL random[%0d]: out=%h lat=%0d rdy_low=%b required %h/6/1 (in=%h sh=%0d ar=%b)",
                     n, r, lat, rl, exp_q[0], d, s, a);
         end
         void'(exp_q.pop_front());
         if (!hold) begin
            stall = $urandom_range(0, 3);
            for (int i = 0; i < stall; i++) begin
               @(posedge clk); #1;
               checks++;
               if (out_valid !== 1'b1 || dout !== r) begin
                  errors++;
                  $display("FAIL random_stall[%0d]: ov=%b out=%h required 1/%h", n, out_valid, dout, r);
               end
            end
            out_ready = 1'b1;
         end
         @(posedge clk); #1;
         out_ready = 1'b0;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_dup[%0d]: out_valid=%b after handshake required 0", n, out_valid);
         end
      end
      checks++;
      if (got != 1000 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL random_count: results=%0d pending=%0d required 1000/0", got, exp_q.size());
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_backpressure;
      test_reset_midshift;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_right_iterative.md
Name: shift_right_iterative

Overview:
- Multi-cycle right shifter; the right-shift counterpart to the ALU's combinational left-shift path, for SRL/SRA.
- Resolves one shamt bit per clock, log-stage style, so area is a single N-bit 2:1 mux row plus registers instead of an N-way mux tree.
- Sits beside the ALU behind a valid/ready handshake. The controller stalls on it like any other multi-cycle unit.

Parameters:
- N, 32, data width. Must be a power of 2 and at least 2.
- L, $clog2(N), number of shift stages. Derived; not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand presented.
- in_ready  output  1  unit can accept an operand.
- in  input  N  value to shift.
- shamt  input  L  shift amount, 0..N-1.
- arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out  output  N  shifted result.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. On reset: state=IDLE, in_ready=1, out_valid=0, busy=0, out=0, stage counter=0.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in to the data register, shamt to the amount register, and fill = arith & in[N-1].
  - Clear counter k=0 and go to SHIFT.
- SHIFT:
  - in_ready=0. Each cycle: if amt[k]=1, data <= {fill replicated 2^k times, data[N-1:2^k]}; otherwise data holds.
  - k increments each cycle. After the cycle with k=L-1, go to DONE.
  - Always exactly L cycles, independent of shamt.
- DONE:
  - out_valid=1 and out=data, held stable until out_ready.
  - On out_ready, go to IDLE next cycle; out_valid drops.
  - in_valid is ignored in DONE; no bypass.
- Latency: accept edge to out_valid = L+1 edges (6 for N=32). Minimum initiation interval = L+2 cycles.
- out is registered and valid only while out_valid=1. It holds the last result after DONE exits.
- shamt=0: out=in for both modes.
- shamt=N-1 logical: out = {(N-1) zeros, in[N-1]}.
- shamt=N-1 arithmetic: out = all copies of in[N-1].
- Inputs are sampled only at acceptance. Changes to in, shamt or arith during SHIFT/DONE have no effect.
- rst asserted mid-SHIFT or in DONE: the operation is abandoned immediately, nothing is emitted, and the unit returns to the reset values.
- out_ready while not in DONE is ignored. out_ready held high continuously is legal: DONE lasts exactly one cycle.

Decomposition:
- Shared ALU package:
  - shifter state enum {S_IDLE, S_SHIFT, S_DONE} (2-bit logic typedef).
  - localparam SHIFT_N=32.
  - shift-mode constants SHIFT_LOGICAL=0, SHIFT_ARITH=1.
- One natural sub-module: shift_right_stage.
  - Combinational; inputs data, stage index k, enable bit, fill.
  - Produces the conditionally shifted word via a generate over k.
  - The top instantiates one copy and muxes by counter.

Test Plan:
- Reset, then in=32'hF000_0000, shamt=4, arith=0, in_valid pulse, out_ready=1 -> out_valid rises 6 edges after acceptance, out=32'h0F00_0000, in_ready low throughout.
- Same operand with arith=1 -> out=32'hFF00_0000. Then in=32'h8000_0001, shamt=31, arith=1 -> out=32'hFFFF_FFFF; with arith=0 -> out=32'h0000_0001.
- in=32'hDEAD_BEEF, shamt=0, both modes -> out=32'hDEAD_BEEF with latency still 6.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out and out_valid stable. A new in_valid during the stall is not accepted (in_ready=0). Raise out_ready -> IDLE next cycle, then the new operand is accepted.
- Assert rst during SHIFT cycle 3 -> out_valid, busy and out go 0 asynchronously. After release, in_ready=1, and the next op in=32'h0000_0100, shamt=8, arith=0 gives out=32'h0000_0001.
- Random sweep, 1000 ops with random in/shamt/arith and random out_ready -> out matches the reference model (in >> shamt, or $signed(in) >>> shamt) on every accepted transaction, with no lost or duplicated results.
